// File: rtl/rnd_pkg.sv
// Shared definitions for the RND serial link: state encoding and default word width.
package rnd_pkg;

    localparam int RND_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rnd_state_e;

endpackage

// File: rtl/rnd_piso_reg.sv
// Parallel-in, serial-out shift register presenting its MSB; load wins over shift.
module rnd_piso_reg
    import rnd_pkg::*;
#(
    parameter int WIDTH = RND_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    output logic             msb
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = load_data;
        end else if (shift) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign msb = shreg_q[WIDTH-1];

endmodule

// File: rtl/rnd_serializer.sv
// Sends a WIDTH-bit word MSB first, one bit per enabled cycle, to the RND shift register.
module rnd_serializer
    import rnd_pkg::*;
#(
    parameter int WIDTH = RND_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             en,
    output logic             out_bit,
    output logic             out_valid,
    output logic             out_last,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    rnd_state_e       state_q;
    rnd_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             last;
    logic             acc;
    logic             load;
    logic             shift;
    logic             msb;

    assign last = (state_q == SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));
    assign acc  = in_valid & in_ready;

    rnd_piso_reg #(
        .WIDTH(WIDTH)
    ) u_piso (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_data(in_data),
        .shift    (shift),
        .msb      (msb)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A last-bit cycle with in_valid reloads directly, so SHIFT never passes through IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (en) begin
                    if (!last) begin
                        shift = 1'b1;
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (acc) begin
                        load  = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        out_valid = (state_q == SHIFT);
        busy      = (state_q == SHIFT);
        out_bit   = (state_q == SHIFT) & msb;
        out_last  = last;
        in_ready  = (state_q == IDLE) | ((state_q == SHIFT) & en & last);
    end

endmodule

// File: tb/tb_rnd_serializer.sv
// Scoreboarded bench: the stimulus side predicts accepted words, a monitor checks the serial stream.
module tb_rnd_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         en;
    logic         out_bit;
    logic         out_valid;
    logic         out_last;
    logic         busy;

    int errors = 0;
    int checks = 0;

    logic [1:0]   exp_bits[$];
    logic [W-1:0] exp_words[$];
    int           rem = 0;
    logic [W-1:0] rx = '0;

    rnd_serializer #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .en       (en),
        .out_bit  (out_bit),
        .out_valid(out_valid),
        .out_last (out_last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a word occupies the link for exactly W enabled cycles; a new one may
    // enter when the link is empty or when its final bit is being consumed.
    task automatic step(input logic r, input logic e, input logic v, input logic [W-1:0] d);
        logic ready_m;
        rst      = r;
        en       = e;
        in_valid = v;
        in_data  = d;
        @(negedge clk);
        if (!r) begin
            exp_bits.delete();
            exp_words.delete();
            rem = 0;
        end else begin
            ready_m = (rem == 0) || (e && rem == 1);
            chk("in_ready", 32'(in_ready), 32'(ready_m));
            chk("out_valid", 32'(out_valid), 32'(rem != 0));
            chk("busy", 32'(busy), 32'(rem != 0));
            if (v && ready_m) begin
                for (int i = W - 1; i >= 0; i--) begin
                    exp_bits.push_back({d[i], (i == 0)});
                end
                exp_words.push_back(d);
                rem = W;
            end else if (e && rem > 0) begin
                rem--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (!out_valid) begin
                    chk("idle_out_bit", 32'(out_bit), 32'd0);
                    chk("idle_out_last", 32'(out_last), 32'd0);
                end else if (exp_bits.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bit: got out_valid=1 expected no data at %0t", $time);
                end else begin
                    e = exp_bits[0];
                    chk("out_bit", 32'(out_bit), 32'(e[1]));
                    chk("out_last", 32'(out_last), 32'(e[0]));
                    if (en) begin
                        void'(exp_bits.pop_front());
                    end
                end
                if (en) begin
                    rx = {rx[W-2:0], out_bit};
                    if (out_valid && out_last) begin
                        if (exp_words.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL rx_word: got %0h expected no word at %0t", rx, $time);
                        end else begin
                            chk("rx_word", 32'(rx), 32'(exp_words.pop_front()));
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [10:0] stall_en;
        stall_en = 11'b10011011111;
        rst = 1'b0;
        en = 1'b0;
        in_valid = 1'b0;
        in_data = '0;

        // Reset
        step(0, 0, 0, '0);
        step(0, 0, 0, '0);
        step(1, 0, 0, '0);
        chk("rst_out_bit", 32'(out_bit), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);

        // Basic word
        step(1, 1, 1, 8'hA5);
        for (int i = 0; i < W; i++) step(1, 1, 0, '0);

        // Stall pattern
        step(1, 0, 1, 8'h3C);
        for (int i = 10; i >= 0; i--) step(1, stall_en[i], 0, '0);
        step(1, 0, 0, '0);

        // Back-to-back FF then 00
        step(1, 1, 1, 8'hFF);
        for (int i = 0; i < W - 1; i++) step(1, 1, 1, 8'hFF);
        step(1, 1, 1, 8'h00);
        for (int i = 0; i < W; i++) step(1, 1, 0, '0);

        // Reset mid-word, then a clean word
        step(1, 1, 1, 8'hC3);
        for (int i = 0; i < 3; i++) step(1, 1, 0, '0);
        step(0, 1, 0, '0);
        step(1, 0, 0, '0);
        step(1, 1, 1, 8'h81);
        for (int i = 0; i < W; i++) step(1, 1, 0, '0);

        // Idle en
        for (int i = 0; i < 10; i++) step(1, 1, 0, '0);

        // Random traffic with occasional reset
        for (int i = 0; i < 800; i++) begin
            step(logic'($urandom_range(0, 199) != 0),
                 logic'($urandom_range(0, 3) != 0),
                 logic'($urandom_range(0, 1)),
                 W'($urandom));
        end

        for (int i = 0; i < 2 * W; i++) step(1, 1, 0, '0);
        chk("drain_bits", 32'(exp_bits.size()), 32'd0);
        chk("drain_words", 32'(exp_words.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
